// File: rtl/d_mem_arbiter_pkg.sv
// Shared types and constants for the d_mem two-port arbiter.
// Optional build macro ARB_ROUND_ROBIN_EN is consumed only by rr_arbiter_2.
package d_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD,
        RESP
    } state_t;

    localparam int unsigned PORT0      = 0;
    localparam int unsigned PORT1      = 1;
    localparam int unsigned ADDR_WIDTH = 32;

    // First illegal word index for a memory of the given depth.
    function automatic logic [ADDR_WIDTH-1:0] addr_limit(input int unsigned mem_size);
        return ADDR_WIDTH'(mem_size);
    endfunction

endpackage

// File: rtl/d_mem_arbiter_rr_arbiter_2.sv
// Two-way grant logic for the d_mem arbiter.
// ARB_ROUND_ROBIN_EN defined: alternate on contention; undefined: port 0 has fixed priority.
module rr_arbiter_2
    import d_mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Reset to port 1 so port 0 wins the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[PORT1];
        end
    end

    always_comb begin
        grant = '0;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clock, reset, accept};

    always_comb begin
        grant = '0;
        if (valid[PORT0]) begin
            grant[PORT0] = 1'b1;
        end else if (valid[PORT1]) begin
            grant[PORT1] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/d_mem_arbiter.sv
// Shares the single-port d_mem between CPU (port 0) and debug/DMA loader (port 1).
// Arbitration policy selected in rr_arbiter_2 by the ARB_ROUND_ROBIN_EN macro.
module d_mem_arbiter
    import d_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [31:0]           req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [31:0]           req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,
    output logic [31:0]           mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = addr_limit(MEM_SIZE);

    state_t                state, next_state;
    logic [1:0]            grant;
    logic                  accept;
    logic                  sel;
    logic [31:0]           sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_write;

    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  write_q;
    logic                  port_q;
    logic                  err_q;

    assign accept    = (state == IDLE) && (req0_valid || req1_valid);
    assign sel       = grant[PORT1];
    assign sel_addr  = sel ? req1_addr  : req0_addr;
    assign sel_wdata = sel ? req1_wdata : req0_wdata;
    assign sel_write = sel ? req1_write : req0_write;

    rr_arbiter_2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            port_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                write_q <= sel_write;
                port_q  <= sel;
                err_q   <= (sel_addr >= ADDR_LIMIT);
                rdata_q <= '0;
            end
            // Read data is valid one cycle after the memRead strobe.
            if (state == HOLD) begin
                rdata_q <= (!write_q && !err_q) ? mem_read_data : '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ACCESS;
            ACCESS:  next_state = HOLD;
            HOLD:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req0_ready     = accept && grant[PORT0];
        req1_ready     = accept && grant[PORT1];
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        mem_write      = (state == ACCESS) && write_q && !err_q;
        mem_read       = (state == ACCESS) && !write_q && !err_q;
        rsp0_valid     = (state == RESP) && !port_q;
        rsp1_valid     = (state == RESP) && port_q;
        rsp0_rdata     = rsp0_valid ? rdata_q : '0;
        rsp1_rdata     = rsp1_valid ? rdata_q : '0;
        rsp0_err       = rsp0_valid && err_q;
        rsp1_err       = rsp1_valid && err_q;
    end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Self-checking bench for d_mem_arbiter with a behavioural memory and transaction model.
// Honours ARB_ROUND_ROBIN_EN the same way as the design build.
module tb_d_mem_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned MSZ = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req0_write = 1'b0;
    logic [31:0]   req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_write = 1'b0;
    logic [31:0]   req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [31:0]   mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_write, mem_read;
    logic [DW-1:0] mem_read_data = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    d_mem_arbiter #(.DATA_WIDTH(DW), .MEM_SIZE(MSZ)) dut (
        .clock          (clock),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_write     (req0_write),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .rsp0_valid     (rsp0_valid),
        .rsp0_rdata     (rsp0_rdata),
        .rsp0_err       (rsp0_err),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_write     (req1_write),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .rsp1_valid     (rsp1_valid),
        .rsp1_rdata     (rsp1_rdata),
        .rsp1_err       (rsp1_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural d_mem: strobe sampled on the clock, read data appears the following cycle.
    logic [DW-1:0] dmem [0:MSZ-1];
    initial for (int i = 0; i < int'(MSZ); i++) dmem[i] = '0;
    always @(posedge clock) begin
        if (mem_write && mem_address < MSZ) dmem[mem_address[7:0]] <= mem_write_data;
        if (mem_read && mem_address < MSZ) mem_read_data <= dmem[mem_address[7:0]];
    end

    // Observation counters used by the directed tests.
    int wpulses = 0, rpulses = 0, rsp0_cnt = 0, rsp1_cnt = 0;
    logic [DW-1:0] last0_rdata = '0, last1_rdata = '0;
    logic last0_err = 1'b0, last1_err = 1'b0;
    logic mw_prev = 1'b0, mr_prev = 1'b0;
    always @(negedge clock) begin
        if (mem_write && !mw_prev) wpulses++;
        if (mem_read && !mr_prev) rpulses++;
        mw_prev = mem_write;
        mr_prev = mem_read;
        if (rsp0_valid) begin rsp0_cnt++; last0_rdata = rsp0_rdata; last0_err = rsp0_err; end
        if (rsp1_valid) begin rsp1_cnt++; last1_rdata = rsp1_rdata; last1_err = rsp1_err; end
    end

    // Transaction model: one access in flight, strobe at +1, address held +1..+2, response at +3,
    // next handshake no earlier than +4.
    logic [DW-1:0] model_mem [0:MSZ-1];
    initial for (int i = 0; i < int'(MSZ); i++) model_mem[i] = '0;
    bit            txn_active = 0;
    int            txn_start = 0, idle_from = 0;
    bit            t_port, t_write, t_err;
    logic [31:0]   t_addr;
    logic [DW-1:0] t_wdata, t_rdata;
    bit            last_grant = 1;
    bit            pw = 0, pr = 0;

    always @(negedge clock) begin
        int d;
        bit ew, er, ev0, ev1, accepting, g;
        if (cyc >= 1) begin
            d   = txn_active ? (cyc - txn_start) : -1;
            ew  = (d == 1) && t_write && !t_err;
            er  = (d == 1) && !t_write && !t_err;
            ev0 = (d == 3) && !t_port;
            ev1 = (d == 3) && t_port;
            chk("mem_write", {31'd0, mem_write}, {31'd0, ew});
            chk("mem_read", {31'd0, mem_read}, {31'd0, er});
            chk("strobe_overlap_or_repeat",
                {31'd0, (mem_write && mem_read) || (mem_write && pw) || (mem_read && pr)}, 32'd0);
            pw = mem_write;
            pr = mem_read;
            if (d == 1 || d == 2) begin
                chk("mem_address", mem_address, t_addr);
                if (t_write) chk("mem_write_data", mem_write_data, t_wdata);
            end
            chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ev0});
            chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, ev1});
            if (ev0) begin
                chk("rsp0_rdata", rsp0_rdata, t_rdata);
                chk("rsp0_err", {31'd0, rsp0_err}, {31'd0, t_err});
            end
            if (ev1) begin
                chk("rsp1_rdata", rsp1_rdata, t_rdata);
                chk("rsp1_err", {31'd0, rsp1_err}, {31'd0, t_err});
            end

            if (reset) begin
                txn_active = 0;
                idle_from  = cyc + 1;
                last_grant = 1;
            end else begin
                accepting = (cyc >= idle_from) && (req0_valid || req1_valid);
                g = 0;
                if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                    g = (last_grant == 0);
`else
                    g = 0;
`endif
                end else begin
                    g = !req0_valid;
                end
                chk("req0_ready", {31'd0, req0_ready}, {31'd0, accepting && !g});
                chk("req1_ready", {31'd0, req1_ready}, {31'd0, accepting && g});
                if (accepting) begin
                    t_port  = g;
                    t_write = g ? req1_write : req0_write;
                    t_addr  = g ? req1_addr  : req0_addr;
                    t_wdata = g ? req1_wdata : req0_wdata;
                    t_err   = (t_addr >= MSZ);
                    t_rdata = (!t_write && !t_err) ? model_mem[t_addr[7:0]] : '0;
                    if (t_write && !t_err) model_mem[t_addr[7:0]] = t_wdata;
                    txn_active = 1;
                    txn_start  = cyc;
                    idle_from  = cyc + 4;
                    last_grant = g;
                end
            end
        end
    end

    // Presents one or two requests and returns once each has handshaken (first = port granted first).
    task automatic drive(input bit v0, input bit w0, input logic [31:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit w1, input logic [31:0] a1, input logic [DW-1:0] d1,
                         output int first);
        bit done0, done1;
        first = -1;
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
        done0 = !v0;
        done1 = !v1;
        for (int i = 0; i < 40 && !(done0 && done1); i++) begin
            @(negedge clock);
            if (!done0 && req0_ready) begin done0 = 1; if (first < 0) first = 0; end
            if (!done1 && req1_ready) begin done1 = 1; if (first < 0) first = 1; end
            @(posedge clock); #1;
            if (done0) req0_valid = 1'b0;
            if (done1) req1_valid = 1'b0;
        end
        if (!(done0 && done1)) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout actual=no_ready required=ready");
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int f, base;
        bit hs;
        logic [31:0] exp_second;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("reset_strobes", {30'd0, mem_write, mem_read}, 32'd0);
        chk("reset_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        chk("reset_mem_write_data", mem_write_data, 32'd0);
        reset = 1'b0;

        // Store then load through port 0.
        base = wpulses;
        drive(1, 1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0, f);
        settle(4);
        chk("t1_store_pulses", wpulses - base, 32'd1);
        chk("t1_store_err", {31'd0, last0_err}, 32'd0);
        drive(1, 0, 32'd5, 0, 0, 0, 0, 0, f);
        settle(4);
        chk("t1_load_rdata", last0_rdata, 32'hDEADBEEF);
        chk("t1_rsp0_count", rsp0_cnt, 32'd2);

        // Contention: both load in the same idle cycle.
        drive(1, 0, 32'd5, 0, 1, 0, 32'd6, 0, f);
        settle(4);
        chk("t2_first_grant", f, 32'd0);
        chk("t2_port1_rdata", last1_rdata, 32'd0);
        // A lone port-0 access makes port 0 the most recent grant before contending again.
        drive(1, 0, 32'd5, 0, 0, 0, 0, 0, f);
        settle(4);
        drive(1, 0, 32'd5, 0, 1, 0, 32'd6, 0, f);
        settle(4);
`ifdef ARB_ROUND_ROBIN_EN
        exp_second = 32'd1;
`else
        exp_second = 32'd0;
`endif
        chk("t2_second_first_grant", f, exp_second);

        // Range boundary from port 1.
        base = rpulses;
        drive(0, 0, 0, 0, 1, 0, 32'd256, 0, f);
        settle(4);
        chk("t3_err_reads", rpulses - base, 32'd0);
        chk("t3_err_flag", {31'd0, last1_err}, 32'd1);
        chk("t3_err_rdata", last1_rdata, 32'd0);
        drive(0, 0, 0, 0, 1, 0, 32'h8000_0005, 0, f);
        settle(4);
        chk("t3_upper_bit_err", {31'd0, last1_err}, 32'd1);
        drive(0, 0, 0, 0, 1, 1, 32'd255, 32'hA5A5_A5A5, f);
        drive(0, 0, 0, 0, 1, 0, 32'd255, 0, f);
        settle(4);
        chk("t3_last_legal_err", {31'd0, last1_err}, 32'd0);
        chk("t3_last_legal_rdata", last1_rdata, 32'hA5A5_A5A5);

        // Back-to-back stores from port 1.
        base = wpulses;
        drive(0, 0, 0, 0, 1, 1, 32'd1, 32'h1111_1111, f);
        drive(0, 0, 0, 0, 1, 1, 32'd2, 32'h2222_2222, f);
        drive(0, 0, 0, 0, 1, 1, 32'd3, 32'h3333_3333, f);
        settle(4);
        chk("t4_write_pulses", wpulses - base, 32'd3);
        for (int a = 1; a <= 3; a++) begin
            drive(0, 0, 0, 0, 1, 0, a, 0, f);
            settle(4);
            chk("t4_readback", last1_rdata, 32'h1111_1111 * a);
        end

        // Reset while a load is in ACCESS.
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'd5;
        hs = 0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clock);
            hs = req0_ready;
            @(posedge clock); #1;
        end
        chk("t5_handshake_seen", {31'd0, hs}, 32'd1);
        req0_valid = 1'b0;
        reset = 1'b1;
        base = rsp0_cnt;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t5_strobes_after_reset", {30'd0, mem_write, mem_read}, 32'd0);
        settle(6);
        chk("t5_no_response", rsp0_cnt - base, 32'd0);
        drive(1, 0, 32'd5, 0, 0, 0, 0, 0, f);
        settle(4);
        chk("t5_reissue_rdata", last0_rdata, 32'hDEADBEEF);
        chk("t5_reissue_count", rsp0_cnt - base, 32'd1);

        settle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
